ternary_threshold_packer: RTL and testbench

- Sits directly downstream of the multiply-accumulate stage.
- Takes each completed signed accumulator sum, one channel at a time, and applies a per-channel pair of thresholds (the folded batch-norm). The result is a 2-bit ternary activation.
- Packs NO_CH consecutive activations into one vector in the same 2-bit-per-element encoding the MAC uses for w_vec/data_in. That vector feeds the next layer through a valid/ready handshake with a 2-entry output buffer.

---
 rtl/ternary_threshold_packer.sv | 161 ++++++++++++++++
 tb/tb_ternary_threshold_packer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ternary_threshold_packer.sv
// Per-channel ternary thresholding of signed accumulator sums, packed NO_CH at a time
// into a 2-bit-per-element vector and handed downstream through a 2-entry output buffer.
module ternary_threshold_packer #(
    parameter int IN_BW = 10,
    parameter int NO_CH = 16,
    parameter int CH_BW = $clog2(NO_CH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    thr_wr_en,
    input  logic [CH_BW-1:0]        thr_wr_addr,
    input  logic signed [IN_BW-1:0] thr_wr_lo,
    input  logic signed [IN_BW-1:0] thr_wr_hi,
    input  logic                    sum_vld,
    input  logic signed [IN_BW-1:0] sum_in,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic [2*NO_CH-1:0]      out_data,
    output logic                    ovf
);

    localparam logic [CH_BW-1:0] LAST_CH = CH_BW'(NO_CH - 1);
    localparam logic [1:0] T_POS  = 2'b01;
    localparam logic [1:0] T_NEG  = 2'b11;
    localparam logic [1:0] T_ZERO = 2'b00;

    logic signed [IN_BW-1:0] lo_mem [NO_CH];
    logic signed [IN_BW-1:0] hi_mem [NO_CH];

    logic [CH_BW-1:0]        ch_cnt_q, ch_cnt_d;
    logic                    s1_vld_q;
    logic [CH_BW-1:0]        s1_ch_q;
    logic signed [IN_BW-1:0] s1_sum_q;
    logic signed [IN_BW-1:0] rd_lo_q, rd_hi_q;

    logic                    s2_vld_q;
    logic [CH_BW-1:0]        s2_ch_q;
    logic [1:0]              s2_res_q, s2_res_d;

    logic [2*NO_CH-1:0]      pack_q, pack_d;
    logic                    push;

    logic [2*NO_CH-1:0]      head_q, head_d;
    logic [2*NO_CH-1:0]      tail_q, tail_d;
    logic [1:0]              cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;
    logic                    pop;

    // NOTE: the threshold table has no reset; it holds configuration that must survive a
    // pipeline reset, and leaving it out of the reset tree lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (thr_wr_en) begin
            lo_mem[thr_wr_addr] <= thr_wr_lo;
            hi_mem[thr_wr_addr] <= thr_wr_hi;
        end
    end

    // Synchronous read: a same-cycle write to this address is seen one vector later.
    always_ff @(posedge clk) begin
        if (sum_vld) begin
            rd_lo_q <= lo_mem[ch_cnt_q];
            rd_hi_q <= hi_mem[ch_cnt_q];
        end
    end

    assign ch_cnt_d = (ch_cnt_q == LAST_CH) ? '0 : ch_cnt_q + CH_BW'(1);

    // hi is tested first so an inverted pair (lo > hi) still resolves to +1 above hi.
    assign s2_res_d = (s1_sum_q > rd_hi_q) ? T_POS  :
                      (s1_sum_q < rd_lo_q) ? T_NEG  : T_ZERO;

    assign push = s2_vld_q && (s2_ch_q == LAST_CH);
    assign pop  = (cnt_q != 2'd0) && out_rdy;

    // NOTE: combinational next-state uses blocking assignments with a default first,
    // so every path assigns every variable and no latch is inferred.
    always_comb begin
        pack_d = pack_q;
        if (s2_vld_q) begin
            pack_d[{s2_ch_q, 1'b0} +: 2] = s2_res_q;
        end
    end

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        case (cnt_q)
            2'd0: begin
                if (push) begin
                    head_d = pack_d;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = pack_d;
                end else if (push) begin
                    tail_d = pack_d;
                    cnt_d  = 2'd2;
                end else if (pop) begin
                    cnt_d  = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    head_d = tail_q;
                    if (push) begin
                        tail_d = pack_d;
                    end else begin
                        cnt_d  = 2'd1;
                    end
                end else if (push) begin
                    ovf_d = 1'b1;
                end
            end
        endcase
    end

    // NOTE: all state below updates with non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) begin
            ch_cnt_q <= '0;
            s1_vld_q <= 1'b0;
            s1_ch_q  <= '0;
            s1_sum_q <= '0;
            s2_vld_q <= 1'b0;
            s2_ch_q  <= '0;
            s2_res_q <= T_ZERO;
            pack_q   <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            cnt_q    <= 2'd0;
            ovf_q    <= 1'b0;
        end else begin
            s1_vld_q <= sum_vld;
            if (sum_vld) begin
                s1_sum_q <= sum_in;
                s1_ch_q  <= ch_cnt_q;
                ch_cnt_q <= ch_cnt_d;
            end
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_ch_q  <= s1_ch_q;
                s2_res_q <= s2_res_d;
            end
            pack_q <= pack_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    assign out_vld  = (cnt_q != 2'd0);
    assign out_data = head_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_ternary_threshold_packer.sv
// Randomised scoreboard bench for ternary_threshold_packer: a vector-level model predicts
// each packed output, and a negedge monitor compares every handshake against it.
module tb_ternary_threshold_packer;

    localparam int IN_BW = 10;
    localparam int NO_CH = 16;
    localparam int CH_BW = $clog2(NO_CH);

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    thr_wr_en;
    logic [CH_BW-1:0]        thr_wr_addr;
    logic signed [IN_BW-1:0] thr_wr_lo;
    logic signed [IN_BW-1:0] thr_wr_hi;
    logic                    sum_vld;
    logic signed [IN_BW-1:0] sum_in;
    logic                    out_vld;
    logic                    out_rdy;
    logic [2*NO_CH-1:0]      out_data;
    logic                    ovf;

    ternary_threshold_packer #(.IN_BW(IN_BW), .NO_CH(NO_CH)) dut (
        .clk        (clk),
        .reset      (reset),
        .thr_wr_en  (thr_wr_en),
        .thr_wr_addr(thr_wr_addr),
        .thr_wr_lo  (thr_wr_lo),
        .thr_wr_hi  (thr_wr_hi),
        .sum_vld    (sum_vld),
        .sum_in     (sum_in),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .out_data   (out_data),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    int             lo_m [NO_CH];
    int             hi_m [NO_CH];
    int             part_m [NO_CH];
    int             ch_m = 0;
    logic [31:0]    sb [$];
    bit             bp_mode = 0;
    bit             toggle_rdy = 0;
    int             pop_count = 0;
    logic [31:0]    last_pop = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int tern(input int s, input int lo, input int hi);
        if (s > hi) return 1;
        if (s < lo) return 3;
        return 0;
    endfunction

    // One clock of stimulus; the model sees the table as it was before this cycle's write.
    task automatic drive(input bit vld, input int s, input bit we, input int wa,
                         input int wl, input int wh, input bit rst);
        logic [31:0] vec;
        reset       = rst;
        sum_vld     = vld;
        sum_in      = IN_BW'(s);
        thr_wr_en   = we;
        thr_wr_addr = CH_BW'(wa);
        thr_wr_lo   = IN_BW'(wl);
        thr_wr_hi   = IN_BW'(wh);
        if (toggle_rdy) out_rdy = ~out_rdy;
        if (rst) begin
            ch_m = 0;
            sb.delete();
        end else if (vld) begin
            part_m[ch_m] = tern(s, lo_m[ch_m], hi_m[ch_m]);
            if (ch_m == NO_CH - 1) begin
                vec = '0;
                for (int k = 0; k < NO_CH; k++) vec = vec | (32'(part_m[k]) << (2 * k));
                if (!(bp_mode && sb.size() >= 2)) sb.push_back(vec);
            end
            ch_m = (ch_m + 1) % NO_CH;
        end
        if (we) begin
            lo_m[wa] = wl;
            hi_m[wa] = wh;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic put_sum(input int s);
        drive(1, s, 0, 0, 0, 0, 0);
    endtask

    task automatic wthr(input int a, input int lo, input int hi);
        drive(0, 0, 1, a, lo, hi, 0);
    endtask

    task automatic rst_pulse();
        drive(0, 0, 0, 0, 0, 0, 1);
    endtask

    function automatic int rnd_val();
        return int'($urandom_range(0, 1023)) - 512;
    endfunction

    task automatic drain(input string name);
        for (int i = 0; i < 200 && sb.size() > 0; i++) idle(1);
        idle(4);
        check(name, 64'(sb.size()), 64'd0);
    endtask

    // monitor: pops the scoreboard on every accepted output
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && out_vld && out_rdy) begin
                pop_count++;
                last_pop = out_data;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_vector: got %0h expected none", out_data);
                end else begin
                    check("vector", 64'(out_data), 64'(sb.pop_front()));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops_before;
        reset = 1'b1; sum_vld = 1'b0; sum_in = '0; thr_wr_en = 1'b0;
        thr_wr_addr = '0; thr_wr_lo = '0; thr_wr_hi = '0; out_rdy = 1'b1;
        for (int c = 0; c < NO_CH; c++) begin lo_m[c] = 0; hi_m[c] = 0; part_m[c] = 0; end
        @(posedge clk); #1;
        rst_pulse();
        rst_pulse();
        check("rst_out_vld", 64'(out_vld), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);

        // basic thresholds and exact output latency
        for (int c = 0; c < NO_CH; c++) wthr(c, -3, 5);
        for (int i = 0; i < NO_CH; i++) begin
            case (i)
                0: put_sum(6);
                1: put_sum(5);
                2: put_sum(-3);
                3: put_sum(-4);
                default: put_sum(0);
            endcase
        end
        check("lat_t1_vld", 64'(out_vld), 64'd0);
        idle(1);
        check("lat_t2_vld", 64'(out_vld), 64'd0);
        idle(1);
        check("lat_t3_vld", 64'(out_vld), 64'd1);
        check("lat_t3_data", 64'(out_data), 64'h0000_00C1);
        idle(1);
        check("lat_t4_vld", 64'(out_vld), 64'd0);
        check("basic_ovf", 64'(ovf), 64'd0);
        drain("basic_drain");

        // signed extremes and equality
        wthr(0, -512, 511);
        wthr(1, -512, -512);
        put_sum(-512); put_sum(-511);
        for (int i = 2; i < NO_CH; i++) put_sum(rnd_val());
        put_sum(511); put_sum(-512);
        for (int i = 2; i < NO_CH; i++) put_sum(rnd_val());
        drain("extreme_drain");
        check("extreme_ch", 64'(last_pop[3:0]), 64'h0);

        // write/read collision on ch3
        for (int c = 0; c < NO_CH; c++) wthr(c, -5, 10);
        for (int i = 0; i < NO_CH; i++) begin
            if (i == 3) drive(1, 2, 1, 3, -5, 0, 0);
            else put_sum(2);
        end
        for (int i = 0; i < NO_CH; i++) put_sum(2);
        drain("collide_drain");
        check("collide_second", 64'(last_pop), 64'h0000_0040);

        // back-pressure with a dropped third vector
        out_rdy = 1'b0;
        bp_mode = 1;
        for (int i = 0; i < 3 * NO_CH; i++) put_sum(rnd_val());
        check("bp_ovf_t1", 64'(ovf), 64'd0);
        idle(1);
        check("bp_ovf_t2", 64'(ovf), 64'd0);
        check("bp_vld_t2", 64'(out_vld), 64'd1);
        check("bp_hold_t2", 64'(out_data), 64'(sb[0]));
        idle(1);
        check("bp_ovf_t3", 64'(ovf), 64'd1);
        check("bp_hold_t3", 64'(out_data), 64'(sb[0]));
        bp_mode = 0;
        pops_before = pop_count;
        out_rdy = 1'b1;
        drain("bp_drain");
        check("bp_delivered", 64'(pop_count - pops_before), 64'd2);
        check("bp_ovf_sticky", 64'(ovf), 64'd1);

        // reset mid-vector
        rst_pulse();
        check("rst2_ovf", 64'(ovf), 64'd0);
        check("rst2_vld", 64'(out_vld), 64'd0);
        for (int c = 0; c < NO_CH; c++) wthr(c, -3, 5);
        for (int i = 0; i < 7; i++) put_sum(rnd_val());
        rst_pulse();
        pops_before = pop_count;
        for (int i = 0; i < NO_CH; i++) put_sum(100);
        drain("rst2_drain");
        check("rst2_count", 64'(pop_count - pops_before), 64'd1);
        check("rst2_data", 64'(last_pop), 64'h5555_5555);
        check("rst2_ovf_end", 64'(ovf), 64'd0);

        // gapped random input with toggling ready
        for (int c = 0; c < NO_CH; c++) wthr(c, rnd_val(), rnd_val());
        toggle_rdy = 1;
        pops_before = pop_count;
        for (int i = 0; i < 4 * NO_CH; i++) begin
            put_sum(rnd_val());
            idle(2);
        end
        drain("gap_drain");
        toggle_rdy = 0;
        out_rdy = 1'b1;
        idle(2);
        check("gap_count", 64'(pop_count - pops_before), 64'd4);
        check("gap_ovf", 64'(ovf), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
